// File: rtl/stream_fork_buffered.sv
// Buffered multicast fork: each accepted beat is copied into the FIFO of every
// output selected by in_mask; outputs drain independently of each other.
module stream_fork_buffered #(
  parameter int NumStreams = 2,
  parameter int DataWidth  = 8,
  parameter int Depth      = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [DataWidth-1:0]                     in_data,
  input  logic [NumStreams-1:0]                    in_mask,
  output logic [NumStreams-1:0]                    out_valid,
  input  logic [NumStreams-1:0]                    out_ready,
  output logic [NumStreams*DataWidth-1:0]          out_data,
  output logic [NumStreams*$clog2(Depth+1)-1:0]    out_level
);

  localparam int CntW = $clog2(Depth + 1);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [NumStreams-1:0] full;
  logic                  accept;

  // A full FIFO only blocks the input when the current beat is routed to it.
  assign in_ready = !rst && (&(~in_mask | ~full));
  assign accept   = in_valid && in_ready;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (Depth == 1) return '0;
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar i = 0; i < NumStreams; i++) begin : g_fifo
    logic [DataWidth-1:0] mem_q [2**PtrW];
    logic [PtrW-1:0]      wptr_q, wptr_d;
    logic [PtrW-1:0]      rptr_q, rptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 push, pop;

    assign full[i]      = (cnt_q == CntW'(Depth));
    assign out_valid[i] = (cnt_q != '0);
    assign push         = accept && in_mask[i];
    assign pop          = out_valid[i] && out_ready[i];

    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    // Storage carries no reset; push is already blocked while rst is high.
    always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= in_data;
    end

    assign out_data[i*DataWidth +: DataWidth] = mem_q[rptr_q];
    assign out_level[i*CntW +: CntW]          = cnt_q;
  end

endmodule

// File: tb/tb_stream_fork_buffered.sv
// Directed bench: a 3-output Depth=2 fork and a 1-output Depth=1 fork share clk/rst.
module tb_stream_fork_buffered;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        a_valid, a_ready;
  logic [7:0]  a_data;
  logic [2:0]  a_mask, a_ovalid, a_oready;
  logic [23:0] a_odata;
  logic [5:0]  a_level;

  logic        b_valid, b_ready;
  logic [7:0]  b_data;
  logic [0:0]  b_mask, b_ovalid, b_oready;
  logic [7:0]  b_odata;
  logic [0:0]  b_level;

  int checks = 0;
  int errors = 0;

  stream_fork_buffered #(.NumStreams(3), .DataWidth(8), .Depth(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .in_mask(a_mask), .out_valid(a_ovalid),
    .out_ready(a_oready), .out_data(a_odata), .out_level(a_level)
  );

  stream_fork_buffered #(.NumStreams(1), .DataWidth(8), .Depth(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_mask(b_mask), .out_valid(b_ovalid),
    .out_ready(b_oready), .out_data(b_odata), .out_level(b_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] aod(input int i);
    return a_odata[i*8 +: 8];
  endfunction

  function automatic logic [1:0] alv(input int i);
    return a_level[i*2 +: 2];
  endfunction

  initial begin
    int outs;
    logic [7:0] exp_seq;

    rst = 1'b1;
    a_valid = 1'b0; a_data = 8'h00; a_mask = 3'b111; a_oready = 3'b000;
    b_valid = 1'b0; b_data = 8'h00; b_mask = 1'b1;  b_oready = 1'b1;

    // Reset held three cycles
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_in_ready", a_ready, 0);
      chk("rst_out_valid", a_ovalid, 0);
    end
    rst = 1'b0;
    #1;
    chk("rel_in_ready", a_ready, 1);
    chk("rel_level", a_level, 0);
    chk("rel_out_valid", a_ovalid, 0);

    // Broadcast streaming 0x00..0x0F
    a_mask = 3'b111; a_oready = 3'b111; a_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      a_data = 8'(k);
      #1;
      chk("bc_in_ready", a_ready, 1);
      cyc();
      chk("bc_out_valid", a_ovalid, 3'b111);
      chk("bc_out_data", a_odata, {3{8'(k)}});
    end
    a_valid = 1'b0;
    cyc();
    chk("bc_drain_valid", a_ovalid, 0);
    chk("bc_drain_level", a_level, 0);

    // Independent stall: output 1 blocked
    a_mask = 3'b011; a_oready = 3'b001; a_valid = 1'b1; a_data = 8'h10;
    #1; chk("st_ready0", a_ready, 1);
    cyc();
    a_data = 8'h11;
    chk("st_ready1", a_ready, 1);
    cyc();
    a_data = 8'h12;
    chk("st_ready_full", a_ready, 0);
    chk("st_level1", alv(1), 2);
    chk("st_out0", aod(0), 8'h11);
    chk("st_out1_head", aod(1), 8'h10);
    cyc();
    chk("st_ready_hold", a_ready, 0);
    chk("st_out0_empty", a_ovalid[0], 0);
    chk("st_out1_stable", aod(1), 8'h10);
    a_oready = 3'b011;
    #1; chk("st_ready_prepop", a_ready, 0);
    cyc();
    chk("st_ready_release", a_ready, 1);
    chk("st_out1_next", aod(1), 8'h11);
    cyc();
    chk("st_out0_last", aod(0), 8'h12);
    chk("st_out1_last", aod(1), 8'h12);
    a_valid = 1'b0;
    cyc();
    chk("st_drain", a_ovalid, 0);

    // Selective routing
    a_oready = 3'b000; a_valid = 1'b1;
    a_mask = 3'b001; a_data = 8'hA1; #1; chk("sel_r0", a_ready, 1); cyc();
    a_mask = 3'b010; a_data = 8'hB2; #1; chk("sel_r1", a_ready, 1); cyc();
    a_mask = 3'b000; a_data = 8'hC3; #1; chk("sel_r2", a_ready, 1); cyc();
    a_mask = 3'b011; a_data = 8'hD4; #1; chk("sel_r3", a_ready, 1); cyc();
    a_valid = 1'b0;
    chk("sel_levels", a_level, {2'd0, 2'd2, 2'd2});
    chk("sel_head0", aod(0), 8'hA1);
    chk("sel_head1", aod(1), 8'hB2);
    a_oready = 3'b011;
    cyc();
    chk("sel_next0", aod(0), 8'hD4);
    chk("sel_next1", aod(1), 8'hD4);
    chk("sel_levels2", a_level, {2'd0, 2'd1, 2'd1});
    cyc();
    chk("sel_drain", a_ovalid, 0);

    // Masked-off full output
    a_oready = 3'b001; a_valid = 1'b1; a_mask = 3'b010;
    a_data = 8'h20; cyc();
    a_data = 8'h21; cyc();
    chk("mf_level1", alv(1), 2);
    a_mask = 3'b001; a_data = 8'h30;
    #1; chk("mf_ready_a", a_ready, 1);
    cyc();
    chk("mf_out0_a", aod(0), 8'h30);
    a_data = 8'h31;
    #1; chk("mf_ready_b", a_ready, 1);
    cyc();
    chk("mf_out0_b", aod(0), 8'h31);
    a_mask = 3'b011; a_data = 8'h32;
    #1; chk("mf_ready_blk", a_ready, 0);
    cyc();
    chk("mf_ready_blk2", a_ready, 0);
    chk("mf_out0_empty", alv(0), 0);
    a_oready = 3'b011;
    cyc();
    chk("mf_ready_rel", a_ready, 1);
    chk("mf_out1_next", aod(1), 8'h21);
    cyc();
    chk("mf_out0_c", aod(0), 8'h32);
    chk("mf_out1_c", aod(1), 8'h32);
    a_valid = 1'b0;
    cyc();
    chk("mf_drain", a_level, 0);

    // Depth=1 throughput: one beat per two cycles
    outs = 0; exp_seq = 8'h00;
    b_valid = 1'b1; b_data = 8'h00; b_oready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      logic acc;
      acc = b_ready;
      cyc();
      if (acc) b_data = b_data + 8'h01;
      if (b_ovalid[0]) begin
        chk("d1_order", b_odata, exp_seq);
        exp_seq = exp_seq + 8'h01;
        outs++;
      end
    end
    chk("d1_beats", outs, 8);

    // Mid-stream reset with one beat buffered
    b_data = 8'h55;
    #1; chk("d1_ready", b_ready, 1);
    cyc();
    b_valid = 1'b0; b_oready = 1'b0;
    chk("d1_buffered", b_ovalid, 1);
    rst = 1'b1;
    #1; chk("d1_rst_ready", b_ready, 0);
    cyc();
    chk("d1_rst_valid", b_ovalid, 0);
    chk("d1_rst_level", b_level, 0);
    rst = 1'b0;
    b_oready = 1'b1;
    #1; chk("d1_rel_ready", b_ready, 1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("d1_no_emit", b_ovalid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
